// File: rtl/alu_div_sequencer.sv
// Multi-cycle RV32M divide/remainder sequencer. It runs a 32-step restoring division and
// borrows the shared EX-stage ALU for every subtraction and negation.
module alu_div_sequencer #(
  parameter int          XLEN      = 32,
  parameter logic [3:0]  ALU_SUB   = 4'b0111,
  parameter logic [2:0]  SUB_FUNCT = 3'b000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_owner,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  output logic [3:0]      alu_cntl,
  output logic [2:0]      alu_funct,
  input  logic [XLEN-1:0] alu_result
);

  typedef enum logic [2:0] {IDLE, PRE_A, PRE_B, ITER, POST, DONE} state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] a_reg, d_reg, d_abs, rem, q, result_q;
  logic            sign_op, want_rem;
  logic [4:0]      cnt;

  logic            rem_hi, ge, neg_post, div_zero, accept;
  logic [XLEN-1:0] rem_lo, x_sel;

  // Only the divide group (funct3[2]=1) is a valid request.
  assign accept   = start & funct3[2];
  // 33-bit partial remainder: rem_hi is the bit shifted out of rem.
  assign rem_hi   = rem[XLEN-1];
  assign rem_lo   = {rem[XLEN-2:0], q[XLEN-1]};
  assign ge       = rem_hi | (rem_lo >= d_abs);
  assign x_sel    = want_rem ? rem : q;
  assign div_zero = (d_reg == '0);
  assign neg_post = want_rem ? (sign_op & a_reg[XLEN-1])
                             : (sign_op & (a_reg[XLEN-1] ^ d_reg[XLEN-1]) & ~div_zero);
  assign result   = result_q;
  assign stall    = (accept & (state == IDLE)) | busy;

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    alu_owner = 1'b0;
    alu_op1   = '0;
    alu_op2   = '0;
    alu_cntl  = '0;
    alu_funct = '0;
    case (state)
      IDLE:  if (accept && !flush) state_nx = PRE_A;
      PRE_A: begin
        busy = 1'b1; alu_owner = 1'b1; alu_op2 = a_reg; state_nx = PRE_B;
      end
      PRE_B: begin
        busy = 1'b1; alu_owner = 1'b1; alu_op2 = d_reg; state_nx = ITER;
      end
      ITER: begin
        busy = 1'b1; alu_owner = 1'b1; alu_op1 = rem_lo; alu_op2 = d_abs;
        if (cnt == 5'd0) state_nx = POST;
      end
      POST: begin
        busy = 1'b1; alu_owner = 1'b1; alu_op2 = x_sel; state_nx = DONE;
      end
      DONE: begin
        done = 1'b1; state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (alu_owner) begin
      alu_cntl  = ALU_SUB;
      alu_funct = SUB_FUNCT;
    end
    // A kill aborts any in-flight operation; the DONE cycle is already committed.
    if (flush && state != IDLE && state != DONE) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_reg    <= '0;
      d_reg    <= '0;
      d_abs    <= '0;
      rem      <= '0;
      q        <= '0;
      result_q <= '0;
      sign_op  <= 1'b0;
      want_rem <= 1'b0;
      cnt      <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept && !flush) begin
          a_reg    <= dividend;
          d_reg    <= divisor;
          sign_op  <= ~funct3[0];
          want_rem <= funct3[1];
        end
        PRE_A: begin
          q   <= (sign_op & a_reg[XLEN-1]) ? alu_result : a_reg;
          rem <= '0;
        end
        PRE_B: begin
          d_abs <= (sign_op & d_reg[XLEN-1]) ? alu_result : d_reg;
          cnt   <= 5'd31;
        end
        ITER: begin
          rem <= ge ? alu_result : rem_lo;
          q   <= {q[XLEN-2:0], ge};
          cnt <= cnt - 5'd1;
        end
        POST: if (!flush) begin
          if (div_zero) result_q <= want_rem ? a_reg : '1;
          else          result_q <= neg_post ? alu_result : x_sel;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Bench for alu_div_sequencer: an ALU model, a driver issuing directed and random divides,
// and a monitor that scores each done against expected results from a reference model.
module tb_alu_div_sequencer;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] dividend, divisor;
  logic        busy, stall, done, alu_owner;
  logic [31:0] result, alu_op1, alu_op2, alu_result;
  logic [3:0]  alu_cntl;
  logic [2:0]  alu_funct;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = '0;

  always #5 clk = ~clk;

  // Shared ALU: only the SUB encoding produces a difference.
  assign alu_result = (alu_cntl == 4'b0111 && alu_funct == 3'b000) ? alu_op1 - alu_op2
                                                                    : 32'hDEAD_BEEF;

  alu_div_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .dividend(dividend),
    .divisor(divisor), .flush(flush), .busy(busy), .stall(stall), .done(done),
    .result(result), .alu_owner(alu_owner), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_cntl(alu_cntl), .alu_funct(alu_funct), .alu_result(alu_result)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] ref_div(logic [2:0] f, logic [31:0] a, logic [31:0] d);
    logic signed [31:0] sa, sd;
    logic               ovf;
    sa  = a;
    sd  = d;
    ovf = (a == 32'h8000_0000) && (d == 32'hFFFF_FFFF);
    case (f)
      F_DIV:   return (d == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sd);
      F_DIVU:  return (d == 0) ? 32'hFFFF_FFFF : a / d;
      F_REM:   return (d == 0) ? a : ovf ? 32'h0 : 32'(sa % sd);
      default: return (d == 0) ? a : a % d;
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!alu_owner)
        chk("alu_idle_zero", alu_op1 | alu_op2 | {25'b0, alu_cntl, alu_funct}, 32'h0);
      if (done) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got result %h expected no done", result);
        end else begin
          last_result = exp_q.pop_front();
          chk("result", result, last_result);
        end
      end
    end
  end

  // mode: 0 normal, 1 flush at cyc 20, 2 start poke at cyc 10, 3 reset at cyc 15,
  // 4 flush together with start, 5 flush during the DONE cycle
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                        input int mode);
    int n;
    bit seen, busy_ok;
    @(posedge clk); #1;
    start = 1'b1; funct3 = f; dividend = a; divisor = d; flush = (mode == 4);
    #1;
    chk("stall_cyc0", {31'b0, stall}, 32'h1);
    chk("busy_cyc0", {31'b0, busy}, 32'h0);
    if (mode != 4) exp_q.push_back(ref_div(f, a, d));
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; n = 1;
    if (mode == 4) begin
      chk("flush_start_busy", {31'b0, busy}, 32'h0);
      chk("flush_start_owner", {31'b0, alu_owner}, 32'h0);
      return;
    end
    seen = 1'b0; busy_ok = 1'b1;
    while (!seen && n < 60) begin
      if (done) seen = 1'b1;
      else begin
        if (!busy || !stall || !alu_owner) busy_ok = 1'b0;
        if (mode == 2 && n == 10) begin
          start = 1'b1; funct3 = F_DIVU; dividend = $urandom; divisor = $urandom;
        end
        if (mode == 2 && n == 11) start = 1'b0;
        if (mode == 1 && n == 20) flush = 1'b1;
        if (mode == 1 && n == 21) begin
          flush = 1'b0;
          exp_q.delete();
          chk("flush_busy", {31'b0, busy}, 32'h0);
          chk("flush_owner", {31'b0, alu_owner}, 32'h0);
          chk("flush_result_kept", result, last_result);
          repeat (40) @(posedge clk);
          return;
        end
        if (mode == 3 && n == 15) reset = 1'b1;
        if (mode == 3 && n == 16) begin
          reset = 1'b0;
          exp_q.delete();
          last_result = '0;
          chk("rst_busy", {31'b0, busy}, 32'h0);
          chk("rst_stall", {31'b0, stall}, 32'h0);
          chk("rst_done", {31'b0, done}, 32'h0);
          chk("rst_owner", {31'b0, alu_owner}, 32'h0);
          chk("rst_result", result, 32'h0);
          chk("rst_alu", alu_op1 | alu_op2 | {25'b0, alu_cntl, alu_funct}, 32'h0);
          return;
        end
        @(posedge clk); #1;
        n++;
      end
    end
    chk("latency", n, 36);
    chk("busy_window", {31'b0, busy_ok}, 32'h1);
    chk("done_busy", {31'b0, busy}, 32'h0);
    chk("done_stall", {31'b0, stall}, 32'h0);
    if (mode == 5) begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_in_done_idle", {31'b0, busy}, 32'h0);
    end
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, d;
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = '0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_owner", {31'b0, alu_owner}, 32'h0);
    chk("reset_result", result, 32'h0);
    chk("reset_alu", alu_op1 | alu_op2 | {25'b0, alu_cntl, alu_funct}, 32'h0);

    run_op(F_DIVU, 32'd100, 32'd7, 0);
    run_op(F_REM, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(F_REMU, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(F_DIV, 32'd5, 32'd0, 0);
    run_op(F_REM, 32'hFFFF_FFFB, 32'd0, 0);
    run_op(F_DIVU, 32'd0, 32'd0, 0);
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(F_DIVU, 32'd1000, 32'd3, 1);
    run_op(F_DIVU, 32'd9, 32'd3, 0);
    run_op(F_DIV, 32'd12345, 32'hFFFF_FFEF, 2);
    run_op(F_REM, 32'd777, 32'd5, 3);
    run_op(F_DIVU, 32'd50, 32'd5, 0);
    run_op(F_DIV, 32'd60, 32'd6, 4);
    run_op(F_REMU, 32'd61, 32'd6, 5);

    for (int i = 0; i < 30; i++) begin
      f = 3'(3'b100 + 3'($urandom_range(0, 3)));
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       d = 32'h0;
        1:       d = 32'hFFFF_FFFF;
        2:       d = $urandom_range(1, 15);
        default: d = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_op(f, a, d, 0);
    end

    repeat (5) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
